div_request_sequencer: RTL and testbench
========================================

DIV_REQUEST_SEQUENCER -- requirements
Module: div_request_sequencer

Interface
REQ-001 Parameter tamanyo, default 32: operand/result width in bits, two's complement.
REQ-002 Parameter DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-003 CLK  input  1: single clock, all state on rising edge.
REQ-004 RSTa  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: request present.
REQ-006 in_num, in_den  input  tamanyo each: signed dividend and divisor.
REQ-007 in_ready  output  1: request accepted on any cycle with in_valid and in_ready both high.
REQ-008 div_start  output  1: one-cycle start pulse to the downstream divider.
REQ-009 div_num, div_den  output  tamanyo each: operands to the divider; stable while div_start is high.
REQ-010 div_coc, div_res  input  tamanyo each: divider quotient and remainder, valid in the cycle div_done is high.
REQ-011 div_done  input  1: one-cycle divider completion pulse.
REQ-012 out_valid  output  1: result held in the output register.
REQ-013 out_coc, out_res  output  tamanyo each: result quotient and remainder.
REQ-014 out_divzero  output  1: the held result came from a zero divisor.
REQ-015 out_ready  input  1: consumer accepts the result when out_valid and out_ready are both high.
REQ-016 fifo_count  output  $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-017 in_ready SHALL equal (fifo_count != DEPTH); it is registered-state based only and does not depend on a same-cycle pop.
REQ-018 FIFO SHALL preserve request order; results SHALL leave in acceptance order.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT; all other encodings return to IDLE.
REQ-020 IDLE, FIFO not empty and out_valid low (no output pending): pop the head entry. If den != 0, latch num/den into div_num/div_den and go to ISSUE. If den == 0, load the output register and stay in IDLE.
REQ-021 Zero-divisor result: out_coc = all ones, out_res = num, out_divzero = 1, out_valid = 1 on the next cycle; div_start SHALL NOT assert.
REQ-022 ISSUE: div_start = 1 for exactly one cycle, then go to WAIT.
REQ-023 WAIT: on div_done, capture div_coc/div_res, set out_divzero = 0 and out_valid = 1, then go to IDLE; div_done in any other state SHALL be ignored.
REQ-024 div_num/div_den SHALL hold their value from ISSUE until div_done.
REQ-025 out_valid SHALL clear on the cycle after the out_ready handshake; output fields SHALL remain stable while out_valid is high.
REQ-026 Pop is allowed no earlier than the cycle after the out_valid clear; minimum gap between div_done and the next div_start is 2 cycles.
REQ-027 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; full and empty are derived from fifo_count.
REQ-029 Signed arithmetic belongs to the divider; the sequencer SHALL pass operands unmodified.

Reset
REQ-030 While RSTa is low, all of the following SHALL hold: FSM in IDLE, FIFO empty, fifo_count = 0, in_ready = 1, div_start = 0, div_num = div_den = 0, out_valid = 0, out_coc = out_res = 0, out_divzero = 0.
REQ-031 Reset during WAIT SHALL discard the in-flight request; a late div_done after reset SHALL be ignored.

Structure
REQ-032 Package div_seq_pkg SHALL hold the FSM state enum and the default DEPTH constant.
REQ-033 The FIFO SHALL be a sub-module, div_req_fifo, parameterised by tamanyo and DEPTH, storing {num, den}.
REQ-034 The top level SHALL contain only the FSM, operand registers and output register.

Verification
REQ-035 Request 100/7 with tamanyo=32, divider model attached -> one div_start pulse; out_coc = 14, out_res = 2, out_divzero = 0.
REQ-036 Request -100/7 -> out_coc = 0xFFFFFFF2, out_res = 0xFFFFFFFE.
REQ-037 Request 5/0 -> no div_start; out_coc = 0xFFFFFFFF, out_res = 5, out_divzero = 1, out_valid one cycle after the pop.
REQ-038 out_ready held low, 6 requests offered -> 1 result held, 4 requests queued, in_ready = 0, fifo_count = 4; release out_ready -> all results in order (sequence 9/3, 8/0, 7/2, ...).
REQ-039 RSTa pulsed low during WAIT, then div_done arrives -> out_valid stays 0, FIFO empty, next request completes normally.
REQ-040 Push and pop in the same cycle with fifo_count = 2 -> fifo_count stays 2; pointers wrap correctly after more than DEPTH requests.

Source files
------------

// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared FSM state type and default FIFO depth for the division sequencer
package div_seq_pkg;

  // Sequencer control states; the encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } div_state_e;

  localparam int unsigned DIV_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/div_req_fifo.sv
// rtl/div_req_fifo.sv - request FIFO holding {num, den} pairs in acceptance order
//
// Ports:
//   CLK, RSTa              clock, asynchronous active-low reset
//   push_i, push_num_i/den write one request (ignored when full)
//   pop_i                  drop the head entry (ignored when empty)
//   head_num_o/head_den_o  head entry, valid whenever empty_o is low
//   count_o                occupancy, 0..DEPTH
//   full_o, empty_o        derived from count_o
module div_req_fifo #(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   push_i,
  input  logic [tamanyo-1:0]     push_num_i,
  input  logic [tamanyo-1:0]     push_den_i,
  input  logic                   pop_i,
  output logic [tamanyo-1:0]     head_num_o,
  output logic [tamanyo-1:0]     head_den_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [2*tamanyo-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push_ok;
  logic                 pop_ok;

  // Full/empty come from the occupancy counter so the pointers can simply
  // wrap at DEPTH (a power of two) without an extra lap bit.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;

  assign {head_num_o, head_den_o} = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_num_i, push_den_i};
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/div_request_sequencer.sv
// rtl/div_request_sequencer.sv - queues signed division requests and sequences them through an external divider
//
// Ports:
//   CLK, RSTa                  clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake, operands on in_num/in_den
//   div_start                  one-cycle start pulse, operands on div_num/div_den
//   div_done, div_coc, div_res divider completion pulse with quotient/remainder
//   out_valid/out_ready        result handshake, result on out_coc/out_res/out_divzero
//   fifo_count                 queued requests not yet taken by the FSM
module div_request_sequencer
  import div_seq_pkg::*;
#(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned DEPTH   = DIV_DEPTH_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   in_valid,
  input  logic [tamanyo-1:0]     in_num,
  input  logic [tamanyo-1:0]     in_den,
  output logic                   in_ready,
  output logic                   div_start,
  output logic [tamanyo-1:0]     div_num,
  output logic [tamanyo-1:0]     div_den,
  input  logic [tamanyo-1:0]     div_coc,
  input  logic [tamanyo-1:0]     div_res,
  input  logic                   div_done,
  output logic                   out_valid,
  output logic [tamanyo-1:0]     out_coc,
  output logic [tamanyo-1:0]     out_res,
  output logic                   out_divzero,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count
);

  div_state_e         state_q;
  logic               div_start_q;
  logic [tamanyo-1:0] div_num_q;
  logic [tamanyo-1:0] div_den_q;
  logic               out_valid_q;
  logic [tamanyo-1:0] out_coc_q;
  logic [tamanyo-1:0] out_res_q;
  logic               out_divzero_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [tamanyo-1:0] head_num;
  logic [tamanyo-1:0] head_den;
  logic               pop;

  // in_ready looks only at registered occupancy, so a same-cycle pop never
  // opens a slot combinationally.
  assign in_ready = !fifo_full;

  // A request is taken only while the output register is free, which keeps
  // results strictly in acceptance order with a single holding register.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && !out_valid_q;

  div_req_fifo #(
    .tamanyo (tamanyo),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RSTa       (RSTa),
    .push_i     (in_valid && in_ready),
    .push_num_i (in_num),
    .push_den_i (in_den),
    .pop_i      (pop),
    .head_num_o (head_num),
    .head_den_o (head_den),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q       <= ST_IDLE;
      div_start_q   <= 1'b0;
      div_num_q     <= '0;
      div_den_q     <= '0;
      out_valid_q   <= 1'b0;
      out_coc_q     <= '0;
      out_res_q     <= '0;
      out_divzero_q <= 1'b0;
    end else begin
      div_start_q <= 1'b0;

      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (head_den != '0) begin
              // Start pulse is raised on entry so it is high for exactly the ISSUE cycle.
              div_num_q   <= head_num;
              div_den_q   <= head_den;
              div_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end else begin
              // Zero divisor bypasses the divider entirely.
              out_coc_q     <= '1;
              out_res_q     <= head_num;
              out_divzero_q <= 1'b1;
              out_valid_q   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            out_coc_q     <= div_coc;
            out_res_q     <= div_res;
            out_divzero_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign div_start   = div_start_q;
  assign div_num     = div_num_q;
  assign div_den     = div_den_q;
  assign out_valid   = out_valid_q;
  assign out_coc     = out_coc_q;
  assign out_res     = out_res_q;
  assign out_divzero = out_divzero_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// tb/tb_div_request_sequencer.sv - self-checking bench for div_request_sequencer
module tb_div_request_sequencer;

  localparam int TW  = 32;
  localparam int DEP = 4;

  logic          CLK;
  logic          RSTa;
  logic          in_valid;
  logic [TW-1:0] in_num;
  logic [TW-1:0] in_den;
  logic          in_ready;
  logic          div_start;
  logic [TW-1:0] div_num;
  logic [TW-1:0] div_den;
  logic [TW-1:0] div_coc;
  logic [TW-1:0] div_res;
  logic          div_done;
  logic          out_valid;
  logic [TW-1:0] out_coc;
  logic [TW-1:0] out_res;
  logic          out_divzero;
  logic          out_ready;
  logic [$clog2(DEP):0] fifo_count;

  div_request_sequencer #(.tamanyo(TW), .DEPTH(DEP)) dut (
    .CLK         (CLK),
    .RSTa        (RSTa),
    .in_valid    (in_valid),
    .in_num      (in_num),
    .in_den      (in_den),
    .in_ready    (in_ready),
    .div_start   (div_start),
    .div_num     (div_num),
    .div_den     (div_den),
    .div_coc     (div_coc),
    .div_res     (div_res),
    .div_done    (div_done),
    .out_valid   (out_valid),
    .out_coc     (out_coc),
    .out_res     (out_res),
    .out_divzero (out_divzero),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [TW-1:0] num;
    logic [TW-1:0] den;
  } req_t;

  typedef struct {
    logic [TW-1:0] coc;
    logic [TW-1:0] res;
    logic          dz;
  } res_t;

  int total = 0;
  int bad   = 0;

  req_t          iss_q[$];
  res_t          exp_q[$];
  logic [TW-1:0] log_q[$];

  int            busy      = 0;
  int            start_cnt = 0;
  int            div_lat   = 3;
  int            dv_cnt    = 0;
  logic [TW-1:0] dv_num    = '0;
  logic [TW-1:0] dv_den    = '0;
  logic          prev_ov    = 1'b0;
  logic          prev_start = 1'b0;
  logic [TW-1:0] prev_coc   = '0;
  logic [TW-1:0] prev_res   = '0;
  logic          prev_dz    = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Result rule: zero divisor gives all-ones quotient and the dividend as
  // remainder; otherwise truncating signed division.
  function automatic res_t model(input logic [TW-1:0] n, input logic [TW-1:0] d);
    res_t r;
    if (d == '0) begin
      r.coc = '1;
      r.res = n;
      r.dz  = 1'b1;
    end else begin
      r.coc = $signed(n) / $signed(d);
      r.res = $signed(n) % $signed(d);
      r.dz  = 1'b0;
    end
    return r;
  endfunction

  // Compare process and attached divider model, sampled 1 ns before each rising edge.
  initial begin
    div_done = 1'b0;
    div_coc  = '0;
    div_res  = '0;
    forever begin
      @(negedge CLK);
      #4;
      if (div_done) begin
        div_done = 1'b0;
        busy     = 0;
      end
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          if (busy != 0) begin
            chk("div_num_hold", 64'(div_num), 64'(dv_num));
            chk("div_den_hold", 64'(div_den), 64'(dv_den));
          end
          div_done = 1'b1;
          div_coc  = $signed(dv_num) / $signed(dv_den);
          div_res  = $signed(dv_num) % $signed(dv_den);
        end
      end
      if (!RSTa) begin
        chk("rst_fifo_count", 64'(fifo_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_div_start", 64'(div_start), 64'(0));
        chk("rst_div_num", 64'(div_num), 64'(0));
        chk("rst_div_den", 64'(div_den), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_coc", 64'(out_coc), 64'(0));
        chk("rst_out_res", 64'(out_res), 64'(0));
        chk("rst_out_divzero", 64'(out_divzero), 64'(0));
        exp_q.delete();
        iss_q.delete();
        busy       = 0;
        prev_ov    = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (div_start) begin
          start_cnt++;
          chk("start_single_pulse", 64'(prev_start), 64'(0));
          if (iss_q.size() == 0) begin
            note_fail("start_without_request");
          end else begin
            req_t r;
            r = iss_q.pop_front();
            chk("start_den_nonzero", 64'(r.den == '0), 64'(0));
            chk("start_div_num", 64'(div_num), 64'(r.num));
            chk("start_div_den", 64'(div_den), 64'(r.den));
            dv_num = r.num;
            dv_den = r.den;
            dv_cnt = div_lat;
            busy   = 1;
          end
        end
        if (out_valid && !prev_ov && out_divzero) begin
          if (iss_q.size() == 0) begin
            note_fail("divzero_without_request");
          end else begin
            req_t r;
            r = iss_q.pop_front();
            chk("divzero_den_zero", 64'(r.den), 64'(0));
          end
        end
        if (out_valid && prev_ov) begin
          chk("hold_out_coc", 64'(out_coc), 64'(prev_coc));
          chk("hold_out_res", 64'(out_res), 64'(prev_res));
          chk("hold_out_divzero", 64'(out_divzero), 64'(prev_dz));
        end
        // Every accepted, undelivered request is in the FIFO, in the divider, or held.
        chk("occupancy", 64'(exp_q.size()), 64'(32'(fifo_count) + busy + 32'(out_valid)));
        chk("in_ready_rule", 64'(in_ready), 64'(32'(fifo_count) != DEP));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            note_fail("unexpected_result");
          end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("out_coc", 64'(out_coc), 64'(e.coc));
            chk("out_res", 64'(out_res), 64'(e.res));
            chk("out_divzero", 64'(out_divzero), 64'(e.dz));
            log_q.push_back(out_coc);
          end
        end
        if (in_valid && in_ready) begin
          req_t r;
          r.num = in_num;
          r.den = in_den;
          iss_q.push_back(r);
          exp_q.push_back(model(in_num, in_den));
        end
        prev_ov    = out_valid;
        prev_start = div_start;
        prev_coc   = out_coc;
        prev_res   = out_res;
        prev_dz    = out_divzero;
      end
    end
  end

  task automatic push(input logic [TW-1:0] n, input logic [TW-1:0] d);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    while (!in_ready && g < 300) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 300) note_fail("push_timeout");
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int g;
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 100) note_fail("wait_out_valid");
  endtask

  task automatic release_one();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 500) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 500) note_fail("drain_timeout");
  endtask

  logic [TW-1:0] order_exp [6];

  initial begin
    int s0;
    int g;
    RSTa      = 1'b0;
    in_valid  = 1'b0;
    in_num    = '0;
    in_den    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);

    // 100 / 7
    s0 = start_cnt;
    push(32'd100, 32'd7);
    wait_ov();
    chk("lit_100_7_coc", 64'(out_coc), 64'd14);
    chk("lit_100_7_res", 64'(out_res), 64'd2);
    chk("lit_100_7_dz", 64'(out_divzero), 64'd0);
    chk("lit_100_7_starts", 64'(start_cnt - s0), 64'd1);
    release_one();

    // -100 / 7
    push(-32'sd100, 32'd7);
    wait_ov();
    chk("lit_m100_7_coc", 64'(out_coc), 64'hFFFF_FFF2);
    chk("lit_m100_7_res", 64'(out_res), 64'hFFFF_FFFE);
    release_one();

    // 5 / 0: result one cycle after the pop, no divider start
    s0 = start_cnt;
    push(32'd5, 32'd0);
    chk("lit_5_0_ov_before", 64'(out_valid), 64'd0);
    chk("lit_5_0_count_before", 64'(fifo_count), 64'd1);
    @(negedge CLK);
    chk("lit_5_0_ov", 64'(out_valid), 64'd1);
    chk("lit_5_0_count", 64'(fifo_count), 64'd0);
    chk("lit_5_0_coc", 64'(out_coc), 64'hFFFF_FFFF);
    chk("lit_5_0_res", 64'(out_res), 64'd5);
    chk("lit_5_0_dz", 64'(out_divzero), 64'd1);
    chk("lit_5_0_starts", 64'(start_cnt - s0), 64'd0);
    release_one();

    // Back-pressure: one result held, four queued, sixth request stalled
    log_q.delete();
    push(32'd9, 32'd3);
    push(32'd8, 32'd0);
    push(32'd7, 32'd2);
    push(32'd6, 32'd5);
    push(32'd10, -32'sd3);
    in_valid = 1'b1;
    in_num   = 32'd12;
    in_den   = 32'd4;
    repeat (8) @(negedge CLK);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_fifo_count", 64'(fifo_count), 64'd4);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_out_coc", 64'(out_coc), 64'd3);
    out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 300) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 300) note_fail("bp_sixth_push");
    @(negedge CLK);
    in_valid = 1'b0;
    wait_drain();
    order_exp[0] = 32'd3;
    order_exp[1] = 32'hFFFF_FFFF;
    order_exp[2] = 32'd3;
    order_exp[3] = 32'd1;
    order_exp[4] = 32'hFFFF_FFFD;
    order_exp[5] = 32'd3;
    chk("bp_result_count", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) chk($sformatf("bp_order_%0d", i), 64'(log_q[i]), 64'(order_exp[i]));
    end

    // Push and pop on the same edge with two entries queued
    out_ready = 1'b0;
    push(32'd20, 32'd4);
    wait_ov();
    push(32'd21, 32'd0);
    push(32'd22, 32'd0);
    chk("pp_count_pre", 64'(fifo_count), 64'd2);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_num    = 32'd23;
    in_den    = 32'd1;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("pp_count_same", 64'(fifo_count), 64'd2);
    chk("pp_out_res", 64'(out_res), 64'd21);
    out_ready = 1'b1;
    wait_drain();

    // More traffic to exercise pointer wrap
    for (int i = 0; i < 7; i++) begin
      push(32'(1000 + 37 * i), (i % 3 == 1) ? 32'd0 : 32'(i - 3));
    end
    wait_drain();

    // Reset while waiting on the divider, then a late div_done
    div_lat = 8;
    push(32'd50, 32'd6);
    s0 = start_cnt;
    g  = 0;
    while (start_cnt == s0 && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 100) note_fail("rst_wait_start");
    repeat (2) @(negedge CLK);
    RSTa = 1'b0;
    @(negedge CLK);
    RSTa = 1'b1;
    g = 0;
    while (dv_cnt != 0 && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 100) note_fail("rst_late_done");
    repeat (2) @(negedge CLK);
    chk("rst_late_out_valid", 64'(out_valid), 64'd0);
    chk("rst_late_fifo_count", 64'(fifo_count), 64'd0);
    div_lat = 2;
    log_q.delete();
    push(-32'sd9, 32'd4);
    wait_drain();
    chk("post_rst_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) chk("post_rst_coc", 64'(log_q[0]), 64'hFFFF_FFFE);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    note_fail("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
